// File: rtl/filtro_secuenciador_if.sv
// Control bundle between the sample-rate timer, the biquad sequencer and the
// register/MUX/MAC datapath. The sequencer sits on the slave side.
interface filtro_secuenciador_if;
  logic       start;
  logic       en1;
  logic       en2;
  logic       en3;
  logic       en4;
  logic       en5;
  logic       en6;
  logic       en7;
  logic [2:0] selmuxS;
  logic [1:0] selmuxC;
  logic [2:0] selmuxZ;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output start,
    input  en1, en2, en3, en4, en5, en6, en7,
    input  selmuxS, selmuxC, selmuxZ,
    input  busy, done, overrun
  );

  modport slave (
    input  start,
    output en1, en2, en3, en4, en5, en6, en7,
    output selmuxS, selmuxC, selmuxZ,
    output busy, done, overrun
  );
endinterface

// File: rtl/filtro_secuenciador.sv
// Microprogram sequencer for the high-pass biquad: per start strobe it shifts
// the delay line, runs five MAC steps, then pulses done for one cycle.
module filtro_secuenciador #(
  parameter int unsigned ARIT_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  filtro_secuenciador_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(ARIT_LAT);
  localparam logic [2:0] STEP_LAST = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [2:0] lat_q, lat_d;
  logic       overrun_q, overrun_d;

  logic [6:0] enVec;
  logic [6:0] stepDest;
  logic [2:0] selS;
  logic [1:0] selC;
  logic [2:0] selZ;
  logic       stepLast;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      lat_q     <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      lat_q     <= lat_d;
      overrun_q <= overrun_d;
    end
  end

  // Selects stay fixed for the whole step; the destination register is only
  // enabled in the step's final cycle, once the MAC result has settled.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    lat_d     = lat_q;
    enVec     = 7'd0;
    stepDest  = 7'd0;
    selS      = 3'd0;
    selC      = 2'd0;
    selZ      = 3'd0;
    stepLast  = (lat_q == LAT_LAST);
    overrun_d = overrun_q | (bus.start & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        enVec[2] = 1'b1;
        enVec[3] = 1'b1;
        state_d  = MAC;
        step_d   = 3'd0;
        lat_d    = 3'd0;
      end

      MAC: begin
        case (step_q)
          3'd0: begin selS = 3'd1; selC = 2'd0; selZ = 3'd0; stepDest = 7'b0010000; end
          3'd1: begin selS = 3'd2; selC = 2'd1; selZ = 3'd1; stepDest = 7'b0000010; end
          3'd2: begin selS = 3'd0; selC = 2'd2; selZ = 3'd4; stepDest = 7'b0100000; end
          3'd3: begin selS = 3'd1; selC = 2'd3; selZ = 3'd2; stepDest = 7'b1000000; end
          3'd4: begin selS = 3'd2; selC = 2'd2; selZ = 3'd3; stepDest = 7'b0000001; end
          default: begin stepDest = 7'd0; end
        endcase

        if (stepLast) begin
          enVec = stepDest;
          lat_d = 3'd0;
          if (step_q == STEP_LAST) begin
            state_d = DONE;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.en1     = enVec[0];
  assign bus.en2     = enVec[1];
  assign bus.en3     = enVec[2];
  assign bus.en4     = enVec[3];
  assign bus.en5     = enVec[4];
  assign bus.en6     = enVec[5];
  assign bus.en7     = enVec[6];
  assign bus.selmuxS = selS;
  assign bus.selmuxC = selC;
  assign bus.selmuxZ = selZ;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Randomized bench for filtro_secuenciador: a timeline reference model of the
// control outputs plus a Q8 datapath model checked against the difference equation.
module tb_filtro_secuenciador;

  localparam int STEP_S [5] = '{1, 2, 0, 1, 2};
  localparam int STEP_C [5] = '{0, 1, 2, 3, 2};
  localparam int STEP_Z [5] = '{0, 1, 4, 2, 3};
  localparam int STEP_EN [5] = '{5, 2, 6, 7, 1};

  logic clk = 1'b0;
  logic rstN;
  logic start;
  int   uk;
  int   coefA1, coefA2, coefB0, coefB1;

  int passCount = 0;
  int checkCount = 0;

  filtro_secuenciador_if ifc1 ();
  filtro_secuenciador_if ifc0 ();

  filtro_secuenciador #(.ARIT_LAT(1)) dutLat1 (.clk(clk), .reset(rstN), .bus(ifc1));
  filtro_secuenciador #(.ARIT_LAT(0)) dutLat0 (.clk(clk), .reset(rstN), .bus(ifc0));

  always #5 clk = ~clk;

  assign ifc1.start = start;
  assign ifc0.start = start;

  logic [16:0] obs [2];
  logic        ovrObs [2];

  assign obs[0] = {ifc1.en7, ifc1.en6, ifc1.en5, ifc1.en4, ifc1.en3, ifc1.en2, ifc1.en1,
                   ifc1.selmuxS, ifc1.selmuxC, ifc1.selmuxZ, ifc1.busy, ifc1.done};
  assign obs[1] = {ifc0.en7, ifc0.en6, ifc0.en5, ifc0.en4, ifc0.en3, ifc0.en2, ifc0.en1,
                   ifc0.selmuxS, ifc0.selmuxC, ifc0.selmuxZ, ifc0.busy, ifc0.done};
  assign ovrObs[0] = ifc1.overrun;
  assign ovrObs[1] = ifc0.overrun;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  tag, observed, observed, expected, expected, $time);
  endtask

  function automatic int latOf(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int doneAt(input int i);
    return 2 + 5 * (latOf(i) + 1);
  endfunction

  // Expected control word k cycles into an accepted sample (k=1 is the SHIFT cycle).
  function automatic logic [16:0] expCtl(input int lat, input int k);
    logic [6:0] en;
    logic [2:0] s;
    logic [1:0] c;
    logic [2:0] z;
    logic       busy;
    logic       done;
    int         t;
    int         j;
    int         st;
    en = '0; s = '0; c = '0; z = '0; busy = 1'b0; done = 1'b0;
    t = 2 + 5 * (lat + 1);
    if (k >= 1 && k <= t) busy = 1'b1;
    if (k == 1) begin
      en[2] = 1'b1;
      en[3] = 1'b1;
    end else if (k == t) begin
      done = 1'b1;
    end else if (k >= 2 && k < t) begin
      j  = k - 2;
      st = j / (lat + 1);
      s  = 3'(STEP_S[st]);
      c  = 2'(STEP_C[st]);
      z  = 3'(STEP_Z[st]);
      if (j % (lat + 1) == lat) en[STEP_EN[st] - 1] = 1'b1;
    end
    return {en, s, c, z, busy, done};
  endfunction

  int cyc;
  int startEdge [2];
  int expOvr [2];
  int refF1, refF2, refF, refY;

  function automatic bit isIdle(input int i);
    int k;
    k = cyc - startEdge[i];
    return (k < 1) || (k > doneAt(i));
  endfunction

  // Reference timeline and direct-form filter, advanced on every accepted start.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        startEdge[i] = -1000;
        expOvr[i] = 0;
      end
      refF1 = 0; refF2 = 0; refF = 0; refY = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (isIdle(i)) begin
          if (start) begin
            startEdge[i] = cyc;
            if (i == 0) begin
              refF = uk + ((refF1 * -coefA1) >>> 8) + ((refF2 * -coefA2) >>> 8);
              refY = ((refF * coefB0) >>> 8) + ((refF1 * coefB1) >>> 8) + ((refF2 * coefB0) >>> 8);
              refF2 = refF1;
              refF1 = refF;
            end
          end
        end else if (start) begin
          expOvr[i] = 1;
        end
      end
      cyc++;
    end
  end

  logic [16:0] ctlSnap;
  int dpYk, dpFk, dpFk1, dpFk2, dpAc1, dpAc2, dpAc3;
  int dpSrc, dpCoef, dpAdd, dpRes;
  int fLog[$];
  int yLog[$];

  // Behavioural datapath driven by the sequencer's enables and selects.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dpYk = 0; dpFk = 0; dpFk1 = 0; dpFk2 = 0; dpAc1 = 0; dpAc2 = 0; dpAc3 = 0;
    end else begin
      case (ctlSnap[9:7])
        3'd0: dpSrc = dpFk;
        3'd1: dpSrc = dpFk1;
        3'd2: dpSrc = dpFk2;
        3'd3: dpSrc = dpYk;
        default: dpSrc = uk;
      endcase
      case (ctlSnap[6:5])
        2'd0: dpCoef = -coefA1;
        2'd1: dpCoef = -coefA2;
        2'd2: dpCoef = coefB0;
        default: dpCoef = coefB1;
      endcase
      case (ctlSnap[4:2])
        3'd0: dpAdd = uk;
        3'd1: dpAdd = dpAc1;
        3'd2: dpAdd = dpAc2;
        3'd3: dpAdd = dpAc3;
        default: dpAdd = 0;
      endcase
      dpRes = ((dpSrc * dpCoef) >>> 8) + dpAdd;
      if (ctlSnap[12] && ctlSnap[13]) begin
        dpFk2 = dpFk1;
        dpFk1 = dpFk;
      end
      if (ctlSnap[10]) dpYk = dpRes;
      if (ctlSnap[11]) dpFk = dpRes;
      if (ctlSnap[14]) dpAc1 = dpRes;
      if (ctlSnap[15]) dpAc2 = dpRes;
      if (ctlSnap[16]) dpAc3 = dpRes;
    end
  end

  always @(negedge clk) begin
    int k;
    ctlSnap = obs[0];
    for (int i = 0; i < 2; i++) begin
      k = cyc - startEdge[i];
      checkOutput($sformatf("ctl_lat%0d", latOf(i)), int'(obs[i]),
                  rstN ? int'(expCtl(latOf(i), k)) : 0);
      checkOutput($sformatf("overrun_lat%0d", latOf(i)), int'(ovrObs[i]), rstN ? expOvr[i] : 0);
      if (rstN && i == 0 && k == doneAt(0)) begin
        checkOutput("fk", dpFk, refF);
        checkOutput("yk", dpYk, refY);
        fLog.push_back(dpFk);
        yLog.push_back(dpYk);
      end
    end
  end

  task automatic applyStimulus(input int u, input logic s);
    @(negedge clk);
    uk = u;
    start = s;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1 rstN = 1'b0;
    @(negedge clk);
    #1 rstN = 1'b1;
  endtask

  initial begin
    int lat1At;
    int lat0At;
    rstN = 1'b0;
    start = 1'b0;
    uk = 0;
    coefA1 = 128; coefA2 = 64; coefB0 = 128; coefB1 = -256;
    repeat (3) @(negedge clk);
    #1 rstN = 1'b1;
    repeat (3) applyStimulus(0, 1'b0);

    // single-cycle start: done latency for both arithmetic latencies
    applyStimulus(0, 1'b1);
    lat1At = 0;
    lat0At = 0;
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(0, 1'b0);
      if (ifc1.done && lat1At == 0) lat1At = n;
      if (ifc0.done && lat0At == 0) lat0At = n;
    end
    checkOutput("latency_lat1", lat1At, 12);
    checkOutput("latency_lat0", lat0At, 7);

    // impulse response through the datapath model
    pulseReset();
    fLog.delete();
    yLog.delete();
    foreach (STEP_S[m]) begin
      if (m < 3) begin
        applyStimulus((m == 0) ? 256 : 0, 1'b1);
        repeat (15) applyStimulus((m == 0) ? 256 : 0, 1'b0);
      end
    end
    checkOutput("imp_count", yLog.size(), 3);
    if (yLog.size() == 3) begin
      checkOutput("imp_f0", fLog[0], 256);
      checkOutput("imp_f1", fLog[1], -128);
      checkOutput("imp_f2", fLog[2], 0);
      checkOutput("imp_y0", yLog[0], 128);
      checkOutput("imp_y1", yLog[1], -320);
      checkOutput("imp_y2", yLog[2], 256);
    end

    // start at edges 0 and 5: second is an overrun that sticks
    pulseReset();
    applyStimulus(10, 1'b1);
    repeat (4) applyStimulus(10, 1'b0);
    applyStimulus(10, 1'b1);
    checkOutput("ovr_before", int'(ifc1.overrun), 0);
    applyStimulus(10, 1'b0);
    checkOutput("ovr_cycle6", int'(ifc1.overrun), 1);
    repeat (12) applyStimulus(10, 1'b0);
    applyStimulus(20, 1'b1);
    repeat (15) applyStimulus(20, 1'b0);
    checkOutput("ovr_sticky", int'(ifc1.overrun), 1);

    // start held high for 30 cycles
    pulseReset();
    repeat (30) applyStimulus(100, 1'b1);
    repeat (15) applyStimulus(100, 1'b0);
    checkOutput("ovr_held", int'(ifc1.overrun), 1);

    // reset in the middle of MAC step 2, with overrun already set
    pulseReset();
    applyStimulus(77, 1'b1);
    repeat (2) applyStimulus(77, 1'b0);
    applyStimulus(77, 1'b1);
    repeat (3) applyStimulus(77, 1'b0);
    #1 rstN = 1'b0;
    #1;
    checkOutput("midrst_ctl", int'(obs[0]), 0);
    checkOutput("midrst_ovr", int'(ifc1.overrun), 0);
    @(negedge clk);
    #1 rstN = 1'b1;
    repeat (5) applyStimulus(77, 1'b0);
    applyStimulus(77, 1'b1);
    repeat (15) applyStimulus(77, 1'b0);

    // random coefficients, samples and start pattern
    @(negedge clk);
    #1 rstN = 1'b0;
    coefA1 = int'($urandom_range(0, 192)) - 96;
    coefA2 = int'($urandom_range(0, 192)) - 96;
    coefB0 = int'($urandom_range(0, 512)) - 256;
    coefB1 = int'($urandom_range(0, 512)) - 256;
    @(negedge clk);
    #1 rstN = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (isIdle(0)) uk = int'($urandom_range(0, 1023)) - 512;
      start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
